// File: rtl/decode_stage.sv
// RV32I decode stage: a small circular instruction queue fed by fetch, whose head
// is decoded and captured in a valid/ready output register for execute.
module decode_stage #(
  parameter int XLEN     = 32,
  parameter int IQ_DEPTH = 4,
  parameter int CNT_W    = $clog2(IQ_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [XLEN-1:0]  in_pc_i,
  input  logic [31:0]      in_inst_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  out_pc_o,
  output logic [4:0]       rs1_o,
  output logic [4:0]       rs2_o,
  output logic [4:0]       rd_o,
  output logic [XLEN-1:0]  imm_o,
  output logic             alusrc_o,
  output logic [3:0]       aluop_o,
  output logic             asel_pc_o,
  output logic             jal_o,
  output logic             jalr_o,
  output logic             branch_o,
  output logic [2:0]       br_cond_o,
  output logic             mem_to_reg_o,
  output logic             mem_wen_o,
  output logic             mem_ren_o,
  output logic             reg_wen_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] iq_count_o
);

  localparam int PTR_W = $clog2(IQ_DEPTH);

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SRA   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            alusrc;
    logic [3:0]      aluop;
    logic            asel_pc;
    logic            jal;
    logic            jalr;
    logic            branch;
    logic [2:0]      br_cond;
    logic            mem_to_reg;
    logic            mem_wen;
    logic            mem_ren;
    logic            reg_wen;
    logic            illegal;
  } bundle_t;

  logic [XLEN-1:0]  iq_pc_mem   [IQ_DEPTH];
  logic [31:0]      iq_inst_mem [IQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  bundle_t          out_q, out_d;
  bundle_t          dec;
  logic             full, push, pop, legal;
  logic [31:0]      head_inst;
  logic [XLEN-1:0]  head_pc;
  logic [6:0]       opcode, funct7;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  imm_i, imm_s, imm_b, imm_u, imm_j;

  // A pop frees a slot only at the edge, so a full queue refuses pushes that cycle.
  assign full       = (count_q == CNT_W'(IQ_DEPTH));
  assign in_ready_o = !full;
  assign pop        = (!out_valid_q || out_ready_i) && (count_q != '0) && !flush_i;
  assign push       = in_valid_i && !full && !flush_i;

  assign head_inst = iq_inst_mem[rd_ptr_q];
  assign head_pc   = iq_pc_mem[rd_ptr_q];
  assign opcode    = head_inst[6:0];
  assign funct3    = head_inst[14:12];
  assign funct7    = head_inst[31:25];

  assign imm_i = XLEN'($signed(head_inst[31:20]));
  assign imm_s = XLEN'($signed({head_inst[31:25], head_inst[11:7]}));
  assign imm_b = XLEN'($signed({head_inst[31], head_inst[7], head_inst[30:25],
                                head_inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({head_inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({head_inst[31], head_inst[19:12], head_inst[20],
                                head_inst[30:21], 1'b0}));

  always_comb begin
    dec     = '0;
    legal   = 1'b1;
    dec.pc  = head_pc;
    dec.rs1 = head_inst[19:15];
    dec.rs2 = head_inst[24:20];
    dec.rd  = head_inst[11:7];
    dec.aluop = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        dec.reg_wen = 1'b1;
        legal = (funct7 == 7'b0000000) ||
                ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        case (funct3)
          3'b000:  dec.aluop = funct7[5] ? ALU_SUB : ALU_ADD;
          3'b001:  dec.aluop = ALU_SLL;
          3'b010:  dec.aluop = ALU_SLT;
          3'b011:  dec.aluop = ALU_SLTU;
          3'b100:  dec.aluop = ALU_XOR;
          3'b101:  dec.aluop = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  dec.aluop = ALU_OR;
          default: dec.aluop = ALU_AND;
        endcase
      end
      OPC_OPIMM: begin
        dec.reg_wen = 1'b1;
        dec.alusrc  = 1'b1;
        dec.imm     = imm_i;
        case (funct3)
          3'b000:  dec.aluop = ALU_ADD;
          3'b001: begin
            dec.aluop = ALU_SLL;
            legal     = (funct7 == 7'b0000000);
          end
          3'b010:  dec.aluop = ALU_SLT;
          3'b011:  dec.aluop = ALU_SLTU;
          3'b100:  dec.aluop = ALU_XOR;
          3'b101: begin
            dec.aluop = funct7[5] ? ALU_SRA : ALU_SRL;
            legal     = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          end
          3'b110:  dec.aluop = ALU_OR;
          default: dec.aluop = ALU_AND;
        endcase
      end
      OPC_LOAD: begin
        legal          = (funct3 == 3'b010);
        dec.alusrc     = 1'b1;
        dec.mem_ren    = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_wen    = 1'b1;
        dec.imm        = imm_i;
      end
      OPC_STORE: begin
        legal       = (funct3 == 3'b010);
        dec.alusrc  = 1'b1;
        dec.mem_wen = 1'b1;
        dec.imm     = imm_s;
      end
      OPC_BRANCH: begin
        legal       = (funct3 != 3'b010) && (funct3 != 3'b011);
        dec.aluop   = ALU_SUB;
        dec.branch  = 1'b1;
        dec.br_cond = funct3;
        dec.imm     = imm_b;
      end
      OPC_JAL: begin
        dec.jal     = 1'b1;
        dec.reg_wen = 1'b1;
        dec.imm     = imm_j;
      end
      OPC_JALR: begin
        legal       = (funct3 == 3'b000);
        dec.jalr    = 1'b1;
        dec.reg_wen = 1'b1;
        dec.alusrc  = 1'b1;
        dec.imm     = imm_i;
      end
      OPC_LUI: begin
        dec.aluop   = ALU_PASSB;
        dec.alusrc  = 1'b1;
        dec.reg_wen = 1'b1;
        dec.imm     = imm_u;
      end
      OPC_AUIPC: begin
        dec.asel_pc = 1'b1;
        dec.alusrc  = 1'b1;
        dec.reg_wen = 1'b1;
        dec.imm     = imm_u;
      end
      default: legal = 1'b0;
    endcase
    // Illegal bundles still travel downstream, but can never cause side effects.
    if (!legal) begin
      dec.illegal = 1'b1;
      dec.reg_wen = 1'b0;
      dec.mem_wen = 1'b0;
      dec.mem_ren = 1'b0;
      dec.branch  = 1'b0;
      dec.jal     = 1'b0;
      dec.jalr    = 1'b0;
    end
    if (dec.rd == 5'd0) dec.reg_wen = 1'b0;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (flush_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (pop) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else if (out_ready_i) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      iq_pc_mem[wr_ptr_q]   <= in_pc_i;
      iq_inst_mem[wr_ptr_q] <= in_inst_i;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_pc_o     = out_q.pc;
  assign rs1_o        = out_q.rs1;
  assign rs2_o        = out_q.rs2;
  assign rd_o         = out_q.rd;
  assign imm_o        = out_q.imm;
  assign alusrc_o     = out_q.alusrc;
  assign aluop_o      = out_q.aluop;
  assign asel_pc_o    = out_q.asel_pc;
  assign jal_o        = out_q.jal;
  assign jalr_o       = out_q.jalr;
  assign branch_o     = out_q.branch;
  assign br_cond_o    = out_q.br_cond;
  assign mem_to_reg_o = out_q.mem_to_reg;
  assign mem_wen_o    = out_q.mem_wen;
  assign mem_ren_o    = out_q.mem_ren;
  assign reg_wen_o    = out_q.reg_wen;
  assign illegal_o    = out_q.illegal;
  assign iq_count_o   = count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: queue handshake, back-pressure, flush, reset
// and decode of representative RV32I encodings against hand-computed values.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [31:0] in_pc_i, in_inst_i, out_pc_o, imm_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic        alusrc_o, asel_pc_o, jal_o, jalr_o, branch_o;
  logic [3:0]  aluop_o;
  logic [2:0]  br_cond_o;
  logic        mem_to_reg_o, mem_wen_o, mem_ren_o, reg_wen_o, illegal_o;
  logic [2:0]  iq_count_o;

  int errors = 0;
  int checks = 0;

  decode_stage #(.XLEN(32), .IQ_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_pc_i(in_pc_i), .in_inst_i(in_inst_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_pc_o(out_pc_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .imm_o(imm_o),
    .alusrc_o(alusrc_o), .aluop_o(aluop_o), .asel_pc_o(asel_pc_o),
    .jal_o(jal_o), .jalr_o(jalr_o), .branch_o(branch_o), .br_cond_o(br_cond_o),
    .mem_to_reg_o(mem_to_reg_o), .mem_wen_o(mem_wen_o), .mem_ren_o(mem_ren_o),
    .reg_wen_o(reg_wen_o), .illegal_o(illegal_o), .iq_count_o(iq_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction for exactly one edge, then withdraws it.
  task automatic push_one(input logic [31:0] pc, input logic [31:0] inst);
    in_valid_i = 1'b1;
    in_pc_i    = pc;
    in_inst_i  = inst;
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic push_present(input logic [31:0] pc, input logic [31:0] inst);
    push_one(pc, inst);
    tick();
    $display("decode pc=%08h inst=%08h -> valid=%0b aluop=%0d imm=%08h", pc, inst, out_valid_o, aluop_o, imm_o);
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    in_pc_i = '0; in_inst_i = '0;
    tick(); tick();
    chk("rst_valid", out_valid_o, 1'b0);
    chk("rst_count", iq_count_o, 3'd0);
    chk("rst_ready", in_ready_o, 1'b1);
    chk("rst_imm",   imm_o, 32'h0);
    rst_n = 1'b1;
    tick();

    // addi x1,x0,5: one cycle in the queue, then presented
    push_one(32'h0, 32'h00500093);
    chk("t1_count_after_push", iq_count_o, 3'd1);
    chk("t1_valid_before", out_valid_o, 1'b0);
    tick();
    $display("addi -> valid=%0b rd=%0d imm=%0h aluop=%0d", out_valid_o, rd_o, imm_o, aluop_o);
    chk("t1_valid",  out_valid_o, 1'b1);
    chk("t1_rd",     rd_o, 5'd1);
    chk("t1_imm",    imm_o, 32'h5);
    chk("t1_aluop",  aluop_o, 4'd0);
    chk("t1_alusrc", alusrc_o, 1'b1);
    chk("t1_regwen", reg_wen_o, 1'b1);
    chk("t1_pc",     out_pc_o, 32'h0);
    tick();
    chk("t1_drained", out_valid_o, 1'b0);

    // sub then lui back to back
    in_valid_i = 1'b1; in_pc_i = 32'h4; in_inst_i = 32'h402081B3;
    tick();
    in_pc_i = 32'h8; in_inst_i = 32'h123452B7;
    tick();
    in_valid_i = 1'b0;
    $display("sub -> valid=%0b aluop=%0d rd=%0d", out_valid_o, aluop_o, rd_o);
    chk("t2_sub_valid",  out_valid_o, 1'b1);
    chk("t2_sub_aluop",  aluop_o, 4'd1);
    chk("t2_sub_alusrc", alusrc_o, 1'b0);
    chk("t2_sub_regs",   {rd_o, rs1_o, rs2_o}, {5'd3, 5'd1, 5'd2});
    chk("t2_sub_pc",     out_pc_o, 32'h4);
    tick();
    $display("lui -> valid=%0b aluop=%0d imm=%08h", out_valid_o, aluop_o, imm_o);
    chk("t2_lui_aluop",  aluop_o, 4'd10);
    chk("t2_lui_imm",    imm_o, 32'h12345000);
    chk("t2_lui_regwen", reg_wen_o, 1'b1);
    chk("t2_lui_rd",     rd_o, 5'd5);
    chk("t2_lui_pc",     out_pc_o, 32'h8);
    tick();
    chk("t2_drained", out_valid_o, 1'b0);

    // back-pressure: five addi x<i>,x0,<i> with execute stalled
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_pc_i   = 32'h100 + 32'((i - 1) * 4);
      in_inst_i = (32'(i) << 20) | (32'(i) << 7) | 32'h13;
      tick();
      $display("push pc=%08h count=%0d ready=%0b", in_pc_i, iq_count_o, in_ready_o);
    end
    chk("t3_full_count", iq_count_o, 3'd4);
    chk("t3_full_ready", in_ready_o, 1'b0);
    chk("t3_held_pc",    out_pc_o, 32'h100);
    in_pc_i = 32'h114; in_inst_i = 32'h00600313;
    tick();
    chk("t3_refused_count", iq_count_o, 3'd4);
    chk("t3_held_stable",   {out_valid_o, out_pc_o, rd_o}, {1'b1, 32'h100, 5'd1});
    // release while still offering: a full queue must refuse even as it pops
    in_pc_i = 32'h200; in_inst_i = 32'h00700393;
    out_ready_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    chk("t3_pop_no_push_count", iq_count_o, 3'd3);
    chk("t3_ready_again", in_ready_o, 1'b1);
    for (int i = 2; i <= 5; i++) begin
      if (i > 2) tick();
      $display("drain pc=%08h rd=%0d valid=%0b", out_pc_o, rd_o, out_valid_o);
      chk("t3_drain_pc",    out_pc_o, 32'h100 + 32'((i - 1) * 4));
      chk("t3_drain_rd",    rd_o, 5'(i));
      chk("t3_drain_valid", out_valid_o, 1'b1);
    end
    tick();
    chk("t3_empty", out_valid_o, 1'b0);

    // decode corner cases
    push_present(32'h300, 32'h00000463);
    chk("t4_beq_branch", branch_o, 1'b1);
    chk("t4_beq_cond",   br_cond_o, 3'b000);
    chk("t4_beq_imm",    imm_o, 32'h8);
    chk("t4_beq_aluop",  aluop_o, 4'd1);
    chk("t4_beq_regwen", reg_wen_o, 1'b0);
    push_present(32'h304, 32'hFFFFFFFF);
    chk("t4_ill_valid", out_valid_o, 1'b1);
    chk("t4_ill_flag",  illegal_o, 1'b1);
    chk("t4_ill_enables",
        {reg_wen_o, mem_wen_o, mem_ren_o, branch_o, jal_o, jalr_o}, 6'b0);
    push_present(32'h308, 32'h00100013);
    chk("t4_x0_regwen",  reg_wen_o, 1'b0);
    chk("t4_x0_illegal", illegal_o, 1'b0);
    chk("t4_x0_imm",     imm_o, 32'h1);
    push_present(32'h30C, 32'h0020A423);
    chk("t4_sw_ctl", {mem_wen_o, mem_ren_o, reg_wen_o, alusrc_o}, 4'b1001);
    chk("t4_sw_imm", imm_o, 32'h8);
    push_present(32'h310, 32'hFFDFF0EF);
    chk("t4_jal_ctl", {jal_o, reg_wen_o, jalr_o}, 3'b110);
    chk("t4_jal_imm", imm_o, 32'hFFFFFFFC);
    push_present(32'h314, 32'h00001117);
    chk("t4_auipc_ctl", {asel_pc_o, alusrc_o, reg_wen_o, aluop_o}, {3'b111, 4'd0});
    chk("t4_auipc_imm", imm_o, 32'h1000);
    tick();
    chk("t4_drained", out_valid_o, 1'b0);

    // flush with a coincident push
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_pc_i = 32'h400 + 32'(i * 4); in_inst_i = 32'h00100093;
      tick();
    end
    chk("t5_pre_count", iq_count_o, 3'd3);
    chk("t5_pre_valid", out_valid_o, 1'b1);
    flush_i = 1'b1; in_pc_i = 32'h500;
    tick();
    flush_i = 1'b0; in_valid_i = 1'b0;
    $display("flush -> valid=%0b count=%0d", out_valid_o, iq_count_o);
    chk("t5_flush_valid", out_valid_o, 1'b0);
    chk("t5_flush_count", iq_count_o, 3'd0);
    out_ready_i = 1'b1;
    tick(); tick();
    chk("t5_dropped_push", {out_valid_o, iq_count_o}, {1'b0, 3'd0});
    push_present(32'h600, 32'h00500093);
    chk("t5_resume_pc", {out_valid_o, out_pc_o}, {1'b1, 32'h600});

    // synchronous reset mid-stream under back-pressure
    out_ready_i = 1'b0;
    push_one(32'h700, 32'h00500093);
    push_one(32'h704, 32'h00500093);
    chk("t6_pre_count", iq_count_o, 3'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    $display("reset -> valid=%0b count=%0d pc=%08h", out_valid_o, iq_count_o, out_pc_o);
    chk("t6_rst_valid", out_valid_o, 1'b0);
    chk("t6_rst_count", iq_count_o, 3'd0);
    chk("t6_rst_fields", {out_pc_o, imm_o, rd_o, aluop_o, alusrc_o, reg_wen_o, illegal_o}, '0);
    chk("t6_rst_ready", in_ready_o, 1'b1);
    out_ready_i = 1'b1;
    push_present(32'h800, 32'h123452B7);
    chk("t6_resume", {out_valid_o, out_pc_o, aluop_o}, {1'b1, 32'h800, 4'd10});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
